elbeth_mem_responder: RTL and testbench
=======================================

ELBETH_MEM_RESPONDER -- requirements
Module: elbeth_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, wait states between request capture and response (legal range 0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored (1..64).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_en  input  1  request valid, held by the initiator until mem_ready.
REQ-007 SHALL have port mem_addr  input  8  byte address.
REQ-008 SHALL have port mem_rw  input  4  4'b0000 = read; otherwise write byte-lane mask.
REQ-009 SHALL have port mem_in_data  input  32  write data, lane-aligned.
REQ-010 SHALL have port mem_out_data  output  32  read data.
REQ-011 SHALL have port mem_ready  output  1  one-cycle response strobe.
REQ-012 SHALL have port mem_error  output  1  response carries an error; valid only with mem_ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-014 IDLE with mem_en=1 SHALL capture addr/rw/data and go to WAIT with counter=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
REQ-015 WAIT SHALL decrement the 4-bit counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-016 Response latency SHALL be exactly WAIT_CYCLES+1 cycles after the capture edge: mem_ready high for exactly one cycle in RESP.
REQ-017 RESP SHALL always return to IDLE; mem_en still high in the following IDLE cycle is a new request.
REQ-018 Back-to-back throughput SHALL be one response per WAIT_CYCLES+2 cycles.
REQ-019 mem_en deasserted while in WAIT SHALL abort: return to IDLE, no write, no mem_ready.
REQ-020 Word index SHALL be mem_addr[7:2]; mem_addr[1:0] is ignored except for alignment checks.
REQ-021 Legal write masks SHALL be 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other nonzero mask SHALL raise mem_error.
REQ-022 A write SHALL raise mem_error when mem_addr[1:0] disagrees with the lowest set lane: byte mask lane ≠ addr[1:0]; half mask with addr[0]=1 or lane mismatch; word with addr[1:0]≠0.
REQ-023 Word index ≥ DEPTH_WORDS SHALL raise mem_error for both reads and writes.
REQ-024 Reads SHALL return the full aligned word; size and sign handling is the initiator's job.
REQ-025 A legal write SHALL update only the masked lanes, committed at the end of the RESP cycle; a read in the next transaction returns the new data.
REQ-026 On error: no array write; mem_out_data = 0; mem_error = 1 with mem_ready = 1.
REQ-027 Outside RESP, mem_ready = 0, mem_error = 0 and mem_out_data = 0.

Reset
REQ-028 Reset assertion SHALL force state IDLE, counter 0, mem_ready 0, mem_error 0 and mem_out_data 0 immediately, regardless of clk.
REQ-029 Reset asserted mid-transaction SHALL drop that transaction with no write and no response.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 The shared package SHALL hold the state encodings, the MEM_RW_* mask constants (READ, B0..B3, H0, H1, W) and the 4-bit wait-counter width.
REQ-032 Storage SHALL be one sub-module, elbeth_mem_array: synchronous byte-enabled write with combinational read, no reset.

Verification
REQ-033 WAIT_CYCLES=1: write 0xDEADBEEF to addr 0x10 with rw 1111 -> mem_ready on the 2nd cycle after capture, error 0; then read 0x10 -> 0xDEADBEEF.
REQ-034 Byte write 0x000000AA at addr 0x11 with rw 0010 over a word of 0 -> a read of 0x10 returns 0x0000AA00; rw 0001 at addr 0x11 -> mem_error=1 and the word is unchanged.
REQ-035 Illegal mask 0101 at addr 0x20 -> mem_ready=1, mem_error=1, mem_out_data=0, no write; DEPTH_WORDS=16 read at addr 0x40 -> mem_error=1.
REQ-036 WAIT_CYCLES=3 with mem_en held high across 3 reads -> mem_ready pulses exactly every 5 cycles, one cycle wide.
REQ-037 mem_en dropped during WAIT of a write -> no mem_ready and the array is unchanged; rst driven low during WAIT -> outputs 0 at once, FSM in IDLE, target word unchanged.

Source files
------------

// File: rtl/elbeth_mem_responder_pkg.sv
// Shared types and constants for the elbeth memory responder.
// State encodings, byte-lane mask codes, wait-counter width and the write-legality helper.
package elbeth_mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] MEM_RW_READ = 4'b0000;
    localparam logic [3:0] MEM_RW_B0   = 4'b0001;
    localparam logic [3:0] MEM_RW_B1   = 4'b0010;
    localparam logic [3:0] MEM_RW_B2   = 4'b0100;
    localparam logic [3:0] MEM_RW_B3   = 4'b1000;
    localparam logic [3:0] MEM_RW_H0   = 4'b0011;
    localparam logic [3:0] MEM_RW_H1   = 4'b1100;
    localparam logic [3:0] MEM_RW_W    = 4'b1111;

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  rw;
        logic [31:0] data;
    } req_t;

    // True when a nonzero mask is illegal or its lowest lane disagrees with addr[1:0].
    function automatic logic wr_bad(input logic [3:0] rw, input logic [1:0] lo);
        logic bad;
        case (rw)
            MEM_RW_B0: bad = (lo != 2'd0);
            MEM_RW_B1: bad = (lo != 2'd1);
            MEM_RW_B2: bad = (lo != 2'd2);
            MEM_RW_B3: bad = (lo != 2'd3);
            MEM_RW_H0: bad = (lo != 2'd0);
            MEM_RW_H1: bad = (lo != 2'd2);
            MEM_RW_W:  bad = (lo != 2'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/elbeth_mem_responder_if.sv
// Request/response bundle between an initiator and the memory responder.
// Initiator holds mem_en and the request fields until mem_ready.
interface elbeth_mem_responder_if;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_rw;
    logic [31:0] mem_in_data;
    logic [31:0] mem_out_data;
    logic        mem_ready;
    logic        mem_error;

    modport master (
        output mem_en, mem_addr, mem_rw, mem_in_data,
        input  mem_out_data, mem_ready, mem_error
    );

    modport slave (
        input  mem_en, mem_addr, mem_rw, mem_in_data,
        output mem_out_data, mem_ready, mem_error
    );
endinterface

// File: rtl/elbeth_mem_responder_array.sv
// Word storage with per-byte write enables; no reset on contents.
// Latency: combinational read, write commits on the clock edge.
// Backpressure: none, accepts a write whenever we is high.
module elbeth_mem_array #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [5:0]  idx,
    input  logic [31:0] wdat,
    output logic [31:0] rdat
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             in_range;
    logic [IDX_W-1:0] sel;

    assign in_range = ({1'b0, idx} < 7'(DEPTH_WORDS));
    assign sel      = idx[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[sel][8*i +: 8] <= wdat[8*i +: 8];
                end
            end
        end
    end

    assign rdat = in_range ? mem[sel] : '0;
endmodule

// File: rtl/elbeth_mem_responder.sv
// Single-port memory responder with programmable wait states and error checking.
// Latency: response strobe WAIT_CYCLES+1 cycles after the capture edge, one response per WAIT_CYCLES+2 cycles.
// Backpressure: initiator holds mem_en until mem_ready; dropping it during WAIT aborts the request.
module elbeth_mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_WORDS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    elbeth_mem_responder_if.slave  mem
);
    import elbeth_mem_responder_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q;
    logic             capture;

    logic             in_resp;
    logic             is_read;
    logic             out_of_range;
    logic             resp_err;
    logic [31:0]      rd_dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                req_q.addr <= mem.mem_addr;
                req_q.rw   <= mem.mem_rw;
                req_q.data <= mem.mem_in_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem.mem_en) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!mem.mem_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_resp      = (state_q == RESP);
    assign is_read      = (req_q.rw == MEM_RW_READ);
    assign out_of_range = ({1'b0, req_q.addr[7:2]} >= 7'(DEPTH_WORDS));
    assign resp_err     = out_of_range || (!is_read && wr_bad(req_q.rw, req_q.addr[1:0]));

    // Write lands on the edge that ends RESP; an async reset leaves RESP first and cancels it.
    elbeth_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (in_resp && !is_read && !resp_err),
        .be   (req_q.rw),
        .idx  (req_q.addr[7:2]),
        .wdat (req_q.data),
        .rdat (rd_dat)
    );

    assign mem.mem_ready    = in_resp;
    assign mem.mem_error    = in_resp && resp_err;
    assign mem.mem_out_data = (in_resp && is_read && !resp_err) ? rd_dat : '0;
endmodule

// File: tb/tb_elbeth_mem_responder.sv
// Directed bench: vector table on a WAIT_CYCLES=1/DEPTH_WORDS=16 instance,
// plus hand sequences for abort, reset, throughput (WAIT_CYCLES=3) and zero-wait cases.
module tb_elbeth_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    elbeth_mem_responder_if a_if ();
    elbeth_mem_responder_if b_if ();
    elbeth_mem_responder_if c_if ();

    elbeth_mem_responder #(.WAIT_CYCLES(1), .DEPTH_WORDS(16)) dut_a (.clk(clk), .rst(rst), .mem(a_if.slave));
    elbeth_mem_responder #(.WAIT_CYCLES(3), .DEPTH_WORDS(64)) dut_b (.clk(clk), .rst(rst), .mem(b_if.slave));
    elbeth_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(64)) dut_c (.clk(clk), .rst(rst), .mem(c_if.slave));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  rw;
        logic [31:0] wdat;
        logic        chk_dat;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int which, input logic en, input logic [7:0] addr,
                           input logic [3:0] rw, input logic [31:0] wdat);
        case (which)
            0: begin a_if.mem_en = en; a_if.mem_addr = addr; a_if.mem_rw = rw; a_if.mem_in_data = wdat; end
            1: begin b_if.mem_en = en; b_if.mem_addr = addr; b_if.mem_rw = rw; b_if.mem_in_data = wdat; end
            default: begin c_if.mem_en = en; c_if.mem_addr = addr; c_if.mem_rw = rw; c_if.mem_in_data = wdat; end
        endcase
    endtask

    task automatic get_resp(input int which, output logic rdy, output logic err, output logic [31:0] dat);
        case (which)
            0: begin rdy = a_if.mem_ready; err = a_if.mem_error; dat = a_if.mem_out_data; end
            1: begin rdy = b_if.mem_ready; err = b_if.mem_error; dat = b_if.mem_out_data; end
            default: begin rdy = c_if.mem_ready; err = c_if.mem_error; dat = c_if.mem_out_data; end
        endcase
    endtask

    // lat = edges from the capture edge (counted as 1) until mem_ready is seen; 0 means it never came.
    task automatic do_txn(input int which, input logic [7:0] addr, input logic [3:0] rw,
                          input logic [31:0] wdat, output logic [31:0] dat, output logic err,
                          output int lat, output logic one_wide);
        logic r, e;
        logic [31:0] d;
        dat = '0; err = 1'b0; lat = 0;
        @(negedge clk);
        set_req(which, 1'b1, addr, rw, wdat);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            get_resp(which, r, e, d);
            if (r) begin lat = k; dat = d; err = e; end
        end
        @(negedge clk);
        set_req(which, 1'b0, 8'h00, 4'h0, 32'h0);
        @(posedge clk); #1;
        get_resp(which, r, e, d);
        one_wide = !r;
    endtask

    initial begin
        logic [31:0] dat;
        logic        err, one_wide, r, e, seen;
        logic [31:0] d;
        int          lat;

        vecs[0]  = '{8'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{8'h10, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{8'h10, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0};
        // byte value 0xAA presented on lane 1
        vecs[3]  = '{8'h11, 4'h2, 32'h0000AA00, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{8'h10, 4'h0, 32'h0,        1'b1, 32'h0000AA00, 1'b0};
        vecs[5]  = '{8'h11, 4'h1, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[6]  = '{8'h10, 4'h0, 32'h0,        1'b1, 32'h0000AA00, 1'b0};
        vecs[7]  = '{8'h20, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        vecs[8]  = '{8'h20, 4'h5, 32'h12345678, 1'b1, 32'h0,        1'b1};
        vecs[9]  = '{8'h20, 4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{8'h40, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
        vecs[11] = '{8'h40, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b1};
        vecs[12] = '{8'h13, 4'h0, 32'h0,        1'b1, 32'h0000AA00, 1'b0};
        vecs[13] = '{8'h22, 4'hC, 32'hBEEF0000, 1'b0, 32'h0,        1'b0};
        vecs[14] = '{8'h20, 4'h0, 32'h0,        1'b1, 32'hBEEFF00D, 1'b0};
        vecs[15] = '{8'h21, 4'h3, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[16] = '{8'h20, 4'hC, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[17] = '{8'h22, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[18] = '{8'h23, 4'h8, 32'h11000000, 1'b0, 32'h0,        1'b0};
        vecs[19] = '{8'h20, 4'h7, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
        vecs[20] = '{8'h20, 4'h0, 32'h0,        1'b1, 32'h11EFF00D, 1'b0};
        vecs[21] = '{8'h3C, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        vecs[22] = '{8'h3C, 4'h0, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};
        vecs[23] = '{8'h20, 4'h3, 32'h0000FFFF, 1'b0, 32'h0,        1'b0};
        vecs[24] = '{8'h20, 4'h0, 32'h0,        1'b1, 32'h11EFFFFF, 1'b0};

        set_req(0, 1'b0, 8'h00, 4'h0, 32'h0);
        set_req(1, 1'b0, 8'h00, 4'h0, 32'h0);
        set_req(2, 1'b0, 8'h00, 4'h0, 32'h0);

        #3;
        for (int w = 0; w < 3; w++) begin
            get_resp(w, r, e, d);
            chk($sformatf("reset_ready_%0d", w), {31'b0, r}, 32'h0);
            chk($sformatf("reset_error_%0d", w), {31'b0, e}, 32'h0);
            chk($sformatf("reset_data_%0d", w), d, 32'h0);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            do_txn(0, vecs[i].addr, vecs[i].rw, vecs[i].wdat, dat, err, lat, one_wide);
            chk($sformatf("vec%0d_latency", i), lat, 2);
            chk($sformatf("vec%0d_error", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_ready_width", i), {31'b0, one_wide}, 32'h1);
            if (vecs[i].chk_dat) chk($sformatf("vec%0d_data", i), dat, vecs[i].exp_dat);
        end

        // Abort: mem_en dropped during WAIT of a write.
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 4'hF, 32'hFFFFFFFF);
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h00, 4'h0, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (a_if.mem_ready) seen = 1'b1;
        end
        chk("abort_no_ready", {31'b0, seen}, 32'h0);
        do_txn(0, 8'h10, 4'h0, 32'h0, dat, err, lat, one_wide);
        chk("abort_word_kept", dat, 32'h0000AA00);

        // Reset while RESP of a write is showing: outputs drop at once, write cancelled.
        @(negedge clk);
        set_req(0, 1'b1, 8'h3C, 4'hF, 32'h5A5A5A5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstresp_ready_before", {31'b0, a_if.mem_ready}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rstresp_ready_now", {31'b0, a_if.mem_ready}, 32'h0);
        chk("rstresp_error_now", {31'b0, a_if.mem_error}, 32'h0);
        set_req(0, 1'b0, 8'h00, 4'h0, 32'h0);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        do_txn(0, 8'h3C, 4'h0, 32'h0, dat, err, lat, one_wide);
        chk("rstresp_word_kept", dat, 32'hA5A5A5A5);
        chk("rstresp_latency_after", lat, 2);

        // WAIT_CYCLES=3 instance.
        do_txn(1, 8'h08, 4'hF, 32'h11111111, dat, err, lat, one_wide);
        chk("b_write_latency", lat, 4);
        chk("b_write_error", {31'b0, err}, 32'h0);

        @(negedge clk);
        set_req(1, 1'b1, 8'h08, 4'h0, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            chk($sformatf("thru_edge%0d", k), {31'b0, b_if.mem_ready}, {31'b0, (k % 5) == 4});
            if (b_if.mem_ready) chk($sformatf("thru_data%0d", k), b_if.mem_out_data, 32'h11111111);
        end
        @(negedge clk);
        set_req(1, 1'b0, 8'h00, 4'h0, 32'h0);
        @(posedge clk);

        // Reset during WAIT of a write.
        @(negedge clk);
        set_req(1, 1'b1, 8'h08, 4'hF, 32'h22222222);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rstwait_ready", {31'b0, b_if.mem_ready}, 32'h0);
        chk("rstwait_error", {31'b0, b_if.mem_error}, 32'h0);
        chk("rstwait_data", b_if.mem_out_data, 32'h0);
        set_req(1, 1'b0, 8'h00, 4'h0, 32'h0);
        @(posedge clk); #1;
        chk("rstwait_ready_held", {31'b0, b_if.mem_ready}, 32'h0);
        @(negedge clk); rst = 1'b1;
        do_txn(1, 8'h08, 4'h0, 32'h0, dat, err, lat, one_wide);
        chk("rstwait_word_kept", dat, 32'h11111111);
        chk("rstwait_latency_after", lat, 4);

        // WAIT_CYCLES=0 instance.
        do_txn(2, 8'h04, 4'hF, 32'h0BADC0DE, dat, err, lat, one_wide);
        chk("c_write_latency", lat, 1);
        chk("c_write_ready_width", {31'b0, one_wide}, 32'h1);
        do_txn(2, 8'h04, 4'h0, 32'h0, dat, err, lat, one_wide);
        chk("c_read_latency", lat, 1);
        chk("c_read_data", dat, 32'h0BADC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
